// File: rtl/vga_pixel_pipe.sv
// Pixel stage behind the VGA timing generator: framebuffer read requests or test
// patterns, with sync/blank delayed so RGB, HS and VS leave on the same cycle.
package vga_pkg;
    localparam int unsigned VGA_MAX_H_WIDTH = 12;
    localparam int unsigned VGA_MAX_V_WIDTH = 11;
endpackage

module vga_pixel_pipe
    import vga_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 19,
    parameter int unsigned RD_LATENCY  = 2,
    parameter int unsigned COLOR_WIDTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         hs_i,
    input  logic                         vs_i,
    input  logic                         pixel_enable_i,
    input  logic [VGA_MAX_H_WIDTH-1:0]   hcount_i,
    input  logic [VGA_MAX_V_WIDTH-1:0]   vcount_i,
    input  logic [VGA_MAX_H_WIDTH-1:0]   hd_i,
    input  logic                         we_i,
    input  logic [1:0]                   mode_i,
    input  logic [3*COLOR_WIDTH-1:0]     solid_rgb_i,
    input  logic [ADDR_WIDTH-1:0]        base_i,
    output logic                         mem_req_o,
    output logic [ADDR_WIDTH-1:0]        mem_addr_o,
    input  logic [3*COLOR_WIDTH-1:0]     mem_rdata_i,
    output logic                         vga_hs_o,
    output logic                         vga_vs_o,
    output logic [COLOR_WIDTH-1:0]       vga_r_o,
    output logic [COLOR_WIDTH-1:0]       vga_g_o,
    output logic [COLOR_WIDTH-1:0]       vga_b_o
);
    localparam int unsigned PIPE_LAT = RD_LATENCY + 2;
    localparam int unsigned DLY      = PIPE_LAT - 1;
    localparam int unsigned RGB_W    = 3 * COLOR_WIDTH;
    localparam int unsigned H_W      = VGA_MAX_H_WIDTH;

    typedef enum logic [1:0] {
        MODE_FB    = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_SOLID = 2'd3
    } mode_e;

    logic                        r_vs_prev;
    mode_e                       r_mode;
    logic [ADDR_WIDTH-1:0]       r_base;
    logic [RGB_W-1:0]            r_solid;
    logic [H_W-1:0]              r_bar_w;
    logic [ADDR_WIDTH-1:0]       r_offset;
    logic [H_W-1:0]              r_bar_px;
    logic [2:0]                  r_bar_idx;
    logic                        r_mem_req;
    logic [ADDR_WIDTH-1:0]       r_mem_addr;
    logic [DLY-1:0]              r_hs_dly;
    logic [DLY-1:0]              r_vs_dly;
    logic [DLY-1:0]              r_pe_dly;
    logic [DLY-1:0]              r_fb_dly;
    logic [DLY-1:0][RGB_W-1:0]   r_col_dly;
    logic                        r_vga_hs;
    logic                        r_vga_vs;
    logic [RGB_W-1:0]            r_rgb;

    logic                        w_frame;
    logic [H_W-1:0]              w_bar_w_eff;
    logic                        w_bar_last;
    logic [ADDR_WIDTH-1:0]       w_addr;
    logic [RGB_W-1:0]            w_bar_rgb;
    logic [RGB_W-1:0]            w_chk_rgb;
    logic [RGB_W-1:0]            w_pat_rgb;
    logic                        w_unused_bits;

    assign w_frame       = vs_i & ~r_vs_prev;
    assign w_bar_w_eff   = (r_bar_w == '0) ? H_W'(1) : r_bar_w;
    assign w_bar_last    = (r_bar_px == w_bar_w_eff - H_W'(1));
    assign w_addr        = r_base + r_offset;
    assign w_bar_rgb     = {{COLOR_WIDTH{~r_bar_idx[1]}},
                            {COLOR_WIDTH{~r_bar_idx[2]}},
                            {COLOR_WIDTH{~r_bar_idx[0]}}};
    assign w_chk_rgb     = {RGB_W{hcount_i[4] ^ vcount_i[4]}};
    assign w_unused_bits = ^{hcount_i, vcount_i};

    always_comb begin
        w_pat_rgb = '0;
        case (r_mode)
            MODE_BARS:  w_pat_rgb = w_bar_rgb;
            MODE_CHECK: w_pat_rgb = w_chk_rgb;
            MODE_SOLID: w_pat_rgb = r_solid;
            default:    w_pat_rgb = '0;
        endcase
    end

    // Frame-level configuration only moves on the VS rising edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vs_prev <= 1'b1;
            r_mode    <= MODE_BARS;
            r_base    <= '0;
            r_solid   <= '0;
            r_bar_w   <= H_W'(80);
        end else begin
            r_vs_prev <= vs_i;
            if (w_frame) begin
                r_mode  <= mode_e'(mode_i);
                r_base  <= base_i;
                r_solid <= solid_rgb_i;
            end
            if (we_i) begin
                r_bar_w <= hd_i >> 3;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_offset   <= '0;
            r_bar_px   <= '0;
            r_bar_idx  <= '0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
        end else begin
            if (!vs_i) begin
                r_offset <= '0;
            end else if (pixel_enable_i) begin
                r_offset <= r_offset + ADDR_WIDTH'(1);
            end

            if (!pixel_enable_i) begin
                r_bar_px  <= '0;
                r_bar_idx <= '0;
            end else if (w_bar_last) begin
                r_bar_px <= '0;
                if (r_bar_idx != 3'd7) begin
                    r_bar_idx <= r_bar_idx + 3'd1;
                end
            end else begin
                r_bar_px <= r_bar_px + H_W'(1);
            end

            r_mem_req <= pixel_enable_i && (r_mode == MODE_FB);
            if (pixel_enable_i && (r_mode == MODE_FB)) begin
                r_mem_addr <= w_addr;
            end
        end
    end

    // The mode travels with each pixel so a frame-boundary switch never splits one.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_hs_dly  <= '1;
            r_vs_dly  <= '1;
            r_pe_dly  <= '0;
            r_fb_dly  <= '0;
            r_col_dly <= '0;
            r_vga_hs  <= 1'b1;
            r_vga_vs  <= 1'b1;
            r_rgb     <= '0;
        end else begin
            r_hs_dly  <= {r_hs_dly[DLY-2:0], hs_i};
            r_vs_dly  <= {r_vs_dly[DLY-2:0], vs_i};
            r_pe_dly  <= {r_pe_dly[DLY-2:0], pixel_enable_i};
            r_fb_dly  <= {r_fb_dly[DLY-2:0], (r_mode == MODE_FB)};
            r_col_dly <= {r_col_dly[DLY-2:0], w_pat_rgb};
            r_vga_hs  <= r_hs_dly[DLY-1];
            r_vga_vs  <= r_vs_dly[DLY-1];
            if (!r_pe_dly[DLY-1]) begin
                r_rgb <= '0;
            end else if (r_fb_dly[DLY-1]) begin
                r_rgb <= mem_rdata_i;
            end else begin
                r_rgb <= r_col_dly[DLY-1];
            end
        end
    end

    assign mem_req_o  = r_mem_req;
    assign mem_addr_o = r_mem_addr;
    assign vga_hs_o   = r_vga_hs;
    assign vga_vs_o   = r_vga_vs;
    assign vga_r_o    = r_rgb[RGB_W-1 -: COLOR_WIDTH];
    assign vga_g_o    = r_rgb[2*COLOR_WIDTH-1 -: COLOR_WIDTH];
    assign vga_b_o    = r_rgb[COLOR_WIDTH-1:0];

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Bench for vga_pixel_pipe: emulated timing generator, latency-2 memory and a
// frame-level reference model of requests and aligned outputs.
module tb_vga_pixel_pipe;
    import vga_pkg::*;

    localparam int unsigned AW  = 19;
    localparam int unsigned RDL = 2;
    localparam int unsigned CW  = 4;
    localparam int unsigned LAT = RDL + 2;

    logic                        clk = 1'b0;
    logic                        rst_i;
    logic                        hs_i;
    logic                        vs_i;
    logic                        pixel_enable_i;
    logic [VGA_MAX_H_WIDTH-1:0]  hcount_i;
    logic [VGA_MAX_V_WIDTH-1:0]  vcount_i;
    logic [VGA_MAX_H_WIDTH-1:0]  hd_i;
    logic                        we_i;
    logic [1:0]                  mode_i;
    logic [3*CW-1:0]             solid_rgb_i;
    logic [AW-1:0]               base_i;
    logic                        mem_req_o;
    logic [AW-1:0]               mem_addr_o;
    logic [3*CW-1:0]             mem_rdata_i;
    logic                        vga_hs_o;
    logic                        vga_vs_o;
    logic [CW-1:0]               vga_r_o;
    logic [CW-1:0]               vga_g_o;
    logic [CW-1:0]               vga_b_o;

    always #5 clk = ~clk;

    vga_pixel_pipe #(
        .ADDR_WIDTH  (AW),
        .RD_LATENCY  (RDL),
        .COLOR_WIDTH (CW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .hs_i           (hs_i),
        .vs_i           (vs_i),
        .pixel_enable_i (pixel_enable_i),
        .hcount_i       (hcount_i),
        .vcount_i       (vcount_i),
        .hd_i           (hd_i),
        .we_i           (we_i),
        .mode_i         (mode_i),
        .solid_rgb_i    (solid_rgb_i),
        .base_i         (base_i),
        .mem_req_o      (mem_req_o),
        .mem_addr_o     (mem_addr_o),
        .mem_rdata_i    (mem_rdata_i),
        .vga_hs_o       (vga_hs_o),
        .vga_vs_o       (vga_vs_o),
        .vga_r_o        (vga_r_o),
        .vga_g_o        (vga_g_o),
        .vga_b_o        (vga_b_o)
    );

    int n_err = 0;
    int n_chk = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Memory word stored at each address; high address bits folded in so wrap is visible.
    function automatic logic [11:0] mem_word(input logic [AW-1:0] a);
        return a[11:0] ^ {5'b0, a[18:12]};
    endfunction

    logic [11:0] m_pipe [RDL];
    always @(posedge clk) begin
        m_pipe[0] <= mem_word(mem_addr_o);
        for (int i = 1; i < RDL; i++) m_pipe[i] <= m_pipe[i-1];
    end
    assign mem_rdata_i = m_pipe[RDL-1];

    // Reference model: pixel colour from frame-level rules, then a fixed LAT-deep queue.
    logic [11:0] bar_tbl [8];
    initial bar_tbl = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};

    int            m_mode, m_bw, m_run;
    logic [AW-1:0] m_base, m_off;
    logic [11:0]   m_solid;
    logic          m_vs_prev;
    logic [13:0]   oq [$];
    logic          e_hs, e_vs, e_req;
    logic [11:0]   e_rgb;
    logic [AW-1:0] e_addr;
    bit            chk_en = 1'b0;

    always @(posedge clk) begin
        logic [AW-1:0] a;
        logic [11:0]   col;
        logic [13:0]   ent;
        int            idx;
        int            bw;
        if (rst_i) begin
            m_mode = 1; m_base = '0; m_solid = '0; m_bw = 80;
            m_vs_prev = 1'b1; m_off = '0; m_run = 0;
            e_req = 1'b0; e_addr = '0;
            oq.delete();
            for (int i = 0; i < LAT; i++) oq.push_back({1'b1, 1'b1, 12'h000});
        end else begin
            a  = m_base + m_off;
            bw = (m_bw == 0) ? 1 : m_bw;
            case (m_mode)
                0: col = mem_word(a);
                1: begin
                    idx = m_run / bw;
                    if (idx > 7) idx = 7;
                    col = bar_tbl[idx];
                end
                2: col = (hcount_i[4] ^ vcount_i[4]) ? 12'hFFF : 12'h000;
                default: col = m_solid;
            endcase
            ent = {hs_i, vs_i, pixel_enable_i ? col : 12'h000};
            oq.push_back(ent);
            if (pixel_enable_i && m_mode == 0) begin
                e_req = 1'b1; e_addr = a;
            end else begin
                e_req = 1'b0;
            end
            if (!vs_i) m_off = '0;
            else if (pixel_enable_i) m_off = m_off + 1'b1;
            m_run = pixel_enable_i ? m_run + 1 : 0;
            if (vs_i && !m_vs_prev) begin
                m_mode = int'(mode_i); m_base = base_i; m_solid = solid_rgb_i;
            end
            m_vs_prev = vs_i;
            if (we_i) m_bw = int'(hd_i >> 3);
        end
        ent = oq.pop_front();
        {e_hs, e_vs, e_rgb} = ent;
        chk_en = 1'b1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check_eq("hs", vga_hs_o, e_hs);
            check_eq("vs", vga_vs_o, e_vs);
            check_eq("rgb", {vga_r_o, vga_g_o, vga_b_o}, e_rgb);
            check_eq("req", mem_req_o, e_req);
            check_eq("addr", mem_addr_o, e_addr);
        end
    end

    task automatic run_frame(input int ha, input int va, input int hfp, input int hsw,
                             input int hbp, input int vfp, input int vsw, input int vbp,
                             input logic [1:0] nmode, input logic [AW-1:0] nbase,
                             input logic [11:0] nsolid, input bit do_we,
                             input logic [11:0] nhd, input int rst_at);
        int ht;
        int vt;
        int n;
        int rst_left;
        ht = ha + hfp + hsw + hbp;
        vt = va + vfp + vsw + vbp;
        n = 0;
        rst_left = 0;
        for (int v = 0; v < vt; v++) begin
            for (int h = 0; h < ht; h++) begin
                @(negedge clk);
                hs_i           = !(h >= ha + hfp && h < ha + hfp + hsw);
                vs_i           = !(v >= va + vfp && v < va + vfp + vsw);
                pixel_enable_i = (h < ha) && (v < va);
                hcount_i       = h[VGA_MAX_H_WIDTH-1:0];
                vcount_i       = v[VGA_MAX_V_WIDTH-1:0];
                we_i           = do_we && (v == va + vfp + vsw) && (h == 0);
                hd_i           = nhd;
                if (v == 0 && h == ha / 2) begin
                    mode_i = nmode; base_i = nbase; solid_rgb_i = nsolid;
                end
                if (n == rst_at) rst_left = 3;
                rst_i = (rst_left > 0);
                if (rst_left > 0) rst_left--;
                n++;
            end
        end
    endtask

    initial begin
        int ha, va, rst_at;
        logic [AW-1:0] nb;
        rst_i = 1'b1; hs_i = 1'b1; vs_i = 1'b1; pixel_enable_i = 1'b0;
        hcount_i = '0; vcount_i = '0; hd_i = 12'd640; we_i = 1'b0;
        mode_i = 2'd1; solid_rgb_i = '0; base_i = '0;
        repeat (3) @(negedge clk);
        rst_i = 1'b0; we_i = 1'b1;
        @(negedge clk);
        we_i = 1'b0;
        repeat (2) @(negedge clk);

        // Bars at width 80; mode/base switch mid-frame must wait for the VS edge.
        run_frame(640, 2, 4, 4, 4, 1, 1, 1, 2'd0, 19'h00100, 12'h000, 1'b0, 12'd640, -1);
        // Framebuffer at 0x100 across two full lines.
        run_frame(640, 2, 4, 4, 4, 1, 1, 1, 2'd0, 19'h7FFFE, 12'h000, 1'b0, 12'd640, -1);
        // Address wrap from 0x7FFFE, plus a simultaneous width write at the boundary.
        run_frame(8, 2, 2, 2, 2, 1, 1, 1, 2'd3, 19'h00000, 12'h5A3, 1'b1, 12'd16, -1);
        // Solid frame, then a frame with no display pixels at all.
        run_frame(8, 2, 2, 2, 2, 1, 1, 1, 2'd0, 19'h00040, 12'h000, 1'b1, 12'd0, -1);
        run_frame(8, 0, 2, 2, 2, 1, 1, 1, 2'd1, 19'h00000, 12'h000, 1'b0, 12'd0, -1);

        for (int f = 0; f < 14; f++) begin
            ha = $urandom_range(40, 6);
            va = $urandom_range(4, 1);
            nb = AW'($urandom);
            if (f % 4 == 0) nb = 19'h7FFF0 | AW'($urandom_range(15, 0));
            rst_at = (f == 5 || f == 10) ? $urandom_range(ha - 1, 3) : -1;
            run_frame(ha, va, $urandom_range(6, 1), $urandom_range(6, 1), $urandom_range(6, 1),
                      $urandom_range(2, 1), $urandom_range(2, 1), $urandom_range(2, 1),
                      2'($urandom_range(3, 0)), nb, 12'($urandom),
                      1'($urandom_range(1, 0)), 12'($urandom_range(120, 0)), rst_at);
        end

        @(negedge clk);
        hs_i = 1'b1; vs_i = 1'b1; pixel_enable_i = 1'b0; we_i = 1'b0; rst_i = 1'b0;
        repeat (10) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_pixel_pipe.md
# vga_pixel_pipe

Pixel stage directly downstream of the VGA timing generator. Consumes its sync, counter and pixel-enable outputs, generates framebuffer read requests for a fixed-latency synchronous memory (or an internal test pattern), and delays the sync/blank signals so that RGB, HS and VS leave the block aligned on the same cycle.

## Interface
Parameters:
- `ADDR_WIDTH`, 19: framebuffer word address width. One word holds one pixel.
- `RD_LATENCY`, 2: memory read latency in cycles, from the cycle a request is presented to the cycle `mem_rdata_i` is valid. Legal range 1..4.
- `COLOR_WIDTH`, 4: bits per colour channel.
- `VGA_MAX_H_WIDTH` and `VGA_MAX_V_WIDTH` come from `vga_pkg`.

Ports:
- `clk_i`  in  1  pixel clock; the only clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `hs_i`  in  1  HS from the timing generator; active-low sync.
- `vs_i`  in  1  VS from the timing generator; active-low sync.
- `pixel_enable_i`  in  1  display-area flag.
- `hcount_i`  in  VGA_MAX_H_WIDTH  horizontal count.
- `vcount_i`  in  VGA_MAX_V_WIDTH  vertical count.
- `hd_i`  in  VGA_MAX_H_WIDTH  active width; sampled only when `we_i`=1.
- `we_i`  in  1  configuration write strobe.
- `mode_i`  in  2  0 framebuffer, 1 colour bars, 2 checker, 3 solid.
- `solid_rgb_i`  in  3*COLOR_WIDTH  {r,g,b} colour for mode 3.
- `base_i`  in  ADDR_WIDTH  frame base address.
- `mem_req_o`  out  1  read strobe.
- `mem_addr_o`  out  ADDR_WIDTH  read address.
- `mem_rdata_i`  in  3*COLOR_WIDTH  {r,g,b} read data.
- `vga_hs_o`, `vga_vs_o`  out  1  aligned syncs.
- `vga_r_o`, `vga_g_o`, `vga_b_o`  out  COLOR_WIDTH  colour channels.

## Operation
- **Frame-boundary latch.** A frame boundary is the rising edge of `vs_i`, detected against the registered `vs_prev_ff` (reset value 1). On that edge:
  - `mode_ff` loads `mode_i` (reset value 1, colour bars).
  - `base_ff` loads `base_i` (reset value 0).
  - `solid_ff` loads `solid_rgb_i` (reset value 0).
  - Mid-frame changes on these inputs never take effect.
- **Bar width.** `bar_w_ff` loads `hd_i >> 3` when `we_i`=1. Reset value is 80. A value of 0 is treated as 1.
- **Pixel offset counter.**
  - Cleared while `vs_i`=0.
  - Incremented by 1 for every cycle with `pixel_enable_i`=1.
  - Wraps modulo 2^ADDR_WIDTH.
  - Address = `base_ff` + offset, modulo 2^ADDR_WIDTH. No multiplier.
- **Request stage** (registered, one cycle after input sampling):
  - `mem_req_o` = `pixel_enable_i` && `mode_ff`==0.
  - `mem_addr_o` = current address.
  - When `mem_req_o`=0, `mem_addr_o` holds its previous value.
- **Colour-bar generator.**
  - `bar_px_ff` counts display pixels within a line; `bar_idx_ff` (3 bits) is the current bar.
  - When `bar_px_ff` == `bar_w_ff`-1: `bar_px_ff` goes to 0 and `bar_idx_ff` increments, saturating at 7.
  - Both counters clear whenever `pixel_enable_i`=0.
  - Bar colour, each channel all-ones or all-zeros: r = ~idx[1], g = ~idx[2], b = ~idx[0].
  - This gives the sequence white, yellow, cyan, green, magenta, red, blue, black.
- **Checker.** White if `hcount_i[4]` ^ `vcount_i[4]`, otherwise black (16x16 squares).
- **Delay line.**
  - `hs_i`, `vs_i`, `pixel_enable_i`, and the pattern colour selected by `mode_ff` pass through a shift register of depth PIPE_LAT = RD_LATENCY+2.
  - Delay-line reset values: hs=1, vs=1, pe=0, colour=0.
- **Output register.**
  - If the delayed pe=0: RGB=0.
  - Else if mode 0: RGB = `mem_rdata_i`.
  - Else: RGB = delayed pattern colour.
  - The mode used is the one delayed alongside the pixel, so a boundary change never splits a pixel.
- **Reset.**
  - Outputs after reset: `vga_hs_o`=1, `vga_vs_o`=1, RGB=0, `mem_req_o`=0, `mem_addr_o`=0.
  - Reset mid-frame: all of the above on the cycle after `rst_i` is sampled high. The offset counter and bar counters return to 0, and the pipeline refills with idle values.

## Timing
- Inputs sampled at edge k produce:
  - `mem_req_o`/`mem_addr_o` in cycle k+1;
  - `mem_rdata_i` used in cycle k+1+RD_LATENCY;
  - `vga_*` outputs in cycle k+2+RD_LATENCY.
- Latency from input to `vga_*` outputs is exactly PIPE_LAT cycles in every mode, including pattern modes. This keeps the sync-to-RGB relationship identical to the timing generator's.
- Throughput is one pixel per clock. There is no backpressure; the memory must accept one request per cycle.
- Simultaneous `we_i` and frame boundary: both updates take effect; they are independent registers.
- Frame with zero display pixels: no requests issued, offset stays 0.

## Test plan
- **Reset.** Hold `rst_i` 3 cycles mid-display -> next cycle HS=1, VS=1, RGB=0, `mem_req_o`=0. The first request after release has address = `base_ff`+0.
- **Framebuffer mode.** RD_LATENCY=2, base 0x100, memory returns data = address. First display pixel at input cycle k -> `mem_req_o`=1 with addr 0x100 at k+1; RGB=0x100 at k+4. The 640th display pixel of line 0 -> addr 0x37F; first pixel of line 1 -> addr 0x380.
- **Colour bars.** `hd_i`=640 written via `we_i` -> bar width 80. Input pixels 0, 80, 560, 639 output white, yellow, black, black, with 4-bit channels 0xF/0x0.
- **Mode/base change mid-frame.** Switch `mode_i` 1->0 and `base_i` 0->0x4000 during display -> output stays bars until the next VS rising edge. The following frame's first request has address 0x4000.
- **Alignment.** In all modes, with random porch values, `vga_hs_o`/`vga_vs_o` equal `hs_i`/`vs_i` delayed 4 cycles, and RGB is 0 whenever the delayed `pixel_enable_i`=0.
- **Wrap.** ADDR_WIDTH=19, base 0x7FFFE -> requests 0x7FFFE, 0x7FFFF, 0x00000, 0x00001.
